// File: rtl/tlm_xfer_pkg.sv
// Shared types for the message collector: FSM state encoding and the byte type.
package tlm_xfer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/tlm_msg_collector_if.sv
// Bundles the byte stream from the DUT and the host drain port of the collector.
import tlm_xfer_pkg::*;

interface tlm_msg_collector_if #(
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);

  logic          s_valid;
  logic          s_ready;
  byte_t         s_data;
  logic          s_last;
  logic          msg_avail;
  logic [AW:0]   msg_len;
  logic          msg_trunc;
  logic          rd_start;
  logic          rd_en;
  logic          rd_valid;
  byte_t         rd_data;

  // The collector is the slave; the byte source and host together form the master.
  modport slave (
    input  s_valid, s_data, s_last, rd_start, rd_en,
    output s_ready, msg_avail, msg_len, msg_trunc, rd_valid, rd_data
  );

  modport master (
    output s_valid, s_data, s_last, rd_start, rd_en,
    input  s_ready, msg_avail, msg_len, msg_trunc, rd_valid, rd_data
  );

endinterface

// File: rtl/tlm_byte_ram.sv
// DEPTH x 8 simple dual-port RAM: synchronous write, registered read.
import tlm_xfer_pkg::*;

module tlm_byte_ram #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; it holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tlm_msg_collector.sv
// Captures one framed message from a byte stream, holds it, then lets a host drain it.
import tlm_xfer_pkg::*;

module tlm_msg_collector #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tlm_msg_collector_if.slave   bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t      state;
  state_t      next_state;
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;
  logic [AW:0] msg_len_q;
  logic        trunc_flag;
  logic        msg_trunc_q;
  logic        s_ready_q;
  logic        rd_valid_q;
  logic        xfer;
  logic        full;
  logic        wr_en;
  logic        rd_ok;
  logic        drain_done;
  byte_t       ram_rdata;

  assign xfer       = bus.s_valid && s_ready_q && (state == FILL);
  assign full       = (wr_cnt == DEPTH_W);
  assign wr_en      = xfer && !full;
  assign rd_ok      = (state == DRAIN) && bus.rd_en && (rd_cnt != msg_len_q);
  assign drain_done = (state == DRAIN) && rd_valid_q && (rd_cnt == msg_len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (xfer && bus.s_last) next_state = HOLD;
      HOLD:    if (bus.rd_start)       next_state = DRAIN;
      DRAIN:   if (drain_done)         next_state = FILL;
      default:                         next_state = FILL;
    endcase
  end

  // s_ready is registered so it stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      trunc_flag  <= 1'b0;
      msg_len_q   <= '0;
      msg_trunc_q <= 1'b0;
    end else begin
      s_ready_q  <= (next_state == FILL);
      rd_valid_q <= rd_ok;
      case (state)
        FILL: begin
          if (xfer) begin
            if (full) begin
              trunc_flag <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
            if (bus.s_last) begin
              msg_len_q   <= full ? DEPTH_W : wr_cnt + 1'b1;
              msg_trunc_q <= trunc_flag || full;
            end
          end
        end
        HOLD: begin
          if (bus.rd_start) begin
            rd_cnt <= '0;
          end
        end
        DRAIN: begin
          if (rd_ok) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (drain_done) begin
            wr_cnt      <= '0;
            trunc_flag  <= 1'b0;
            msg_len_q   <= '0;
            msg_trunc_q <= 1'b0;
          end
        end
        default: begin
          wr_cnt <= '0;
        end
      endcase
    end
  end

  tlm_byte_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.s_data),
    .re    (rd_ok),
    .raddr (rd_cnt[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.s_ready   = s_ready_q;
  assign bus.msg_avail = (state == HOLD);
  assign bus.msg_len   = msg_len_q;
  assign bus.msg_trunc = msg_trunc_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = ram_rdata;

endmodule
